// File: rtl/param_frame_receiver.sv
// Oversampling serial frame receiver: bit slicing, sync-word hunt with error tolerance,
// payload and parity capture, and valid/ready word delivery with overflow and lock status.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_HUNT    | shifting bits through sync_sr looking for SYNC_WORD
//  ST_PAYLOAD | sync found, collecting PAYLOAD_W payload bits MSB first
//  ST_PARITY  | payload complete, waiting for the even-parity bit
module param_frame_receiver #(
    parameter int                     OSR       = 8,
    parameter int                     SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0]    SYNC_WORD = 8'hD8,
    parameter int unsigned            MAX_ERR   = 0,
    parameter int                     PAYLOAD_W = 8,
    parameter bit                     PARITY_EN = 1'b1,
    parameter int                     CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_i,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_perr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sync_lock,
    output logic                 overflow,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int PH_W = (OSR > 2) ? $clog2(OSR) : 1;
    localparam int BC_W = (PAYLOAD_W > 2) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0] PH_SLICE = PH_W'(OSR / 2 + 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(PAYLOAD_W - 1);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_PARITY  = 2'd2;

    logic            s1, s2;
    logic [1:0]      samp_hist;
    logic [PH_W-1:0] phase_cnt;
    logic            bit_stb, bit_val;
    logic            s2_edge, vote;

    assign s2_edge = s2 ^ samp_hist[0];
    // s2 is the newest sample, samp_hist holds the two before it
    assign vote = (s2 & samp_hist[0]) | (s2 & samp_hist[1]) | (samp_hist[0] & samp_hist[1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            samp_hist <= '0;
            phase_cnt <= '0;
            bit_stb   <= 1'b0;
            bit_val   <= 1'b0;
        end else begin
            s1        <= data_i;
            s2        <= s1;
            samp_hist <= {samp_hist[0], s2};
            if (s2_edge || phase_cnt == PH_LAST)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + 1'b1;
            bit_stb <= (phase_cnt == PH_SLICE);
            bit_val <= vote;
        end
    end

    function automatic int unsigned popcount(input logic [SYNC_LEN-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < SYNC_LEN; i++)
            if (v[i]) n++;
        return n;
    endfunction

    logic [1:0]           state, state_nxt;
    logic [SYNC_LEN-1:0]  sync_sr, sync_sr_nxt, sync_shift;
    logic [PAYLOAD_W-1:0] pay_sr, pay_sr_nxt, pay_shift;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic                 deliver, dlv_perr;
    logic [PAYLOAD_W-1:0] dlv_data;

    assign sync_shift = {sync_sr[SYNC_LEN-2:0], bit_val};
    assign pay_shift  = {pay_sr[PAYLOAD_W-2:0], bit_val};

    always_comb begin
        state_nxt   = state;
        sync_sr_nxt = sync_sr;
        pay_sr_nxt  = pay_sr;
        bit_cnt_nxt = bit_cnt;
        deliver     = 1'b0;
        dlv_data    = pay_sr;
        dlv_perr    = 1'b0;
        if (bit_stb) begin
            case (state)
                ST_HUNT: begin
                    sync_sr_nxt = sync_shift;
                    if (popcount(sync_shift ^ SYNC_WORD) <= MAX_ERR) begin
                        state_nxt   = ST_PAYLOAD;
                        bit_cnt_nxt = '0;
                    end
                end
                ST_PAYLOAD: begin
                    pay_sr_nxt  = pay_shift;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BC_LAST) begin
                        if (PARITY_EN) begin
                            state_nxt = ST_PARITY;
                        end else begin
                            deliver     = 1'b1;
                            dlv_data    = pay_shift;
                            state_nxt   = ST_HUNT;
                            sync_sr_nxt = '0;
                        end
                    end
                end
                ST_PARITY: begin
                    deliver     = 1'b1;
                    dlv_data    = pay_sr;
                    dlv_perr    = ^{pay_sr, bit_val};
                    state_nxt   = ST_HUNT;
                    sync_sr_nxt = '0;
                end
                default: begin
                    state_nxt   = ST_HUNT;
                    sync_sr_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HUNT;
            sync_sr   <= '0;
            pay_sr    <= '0;
            bit_cnt   <= '0;
            sync_lock <= 1'b0;
            out_data  <= '0;
            out_perr  <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sync_sr   <= sync_sr_nxt;
            pay_sr    <= pay_sr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            sync_lock <= (state_nxt != ST_HUNT);
            if (deliver) begin
                out_data  <= dlv_data;
                out_perr  <= dlv_perr;
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
                // a handshake in the same cycle consumes the old word, so only a stalled word is lost
                if (out_valid && !out_ready)
                    overflow <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_frame_receiver.sv
// Bench for param_frame_receiver: three builds (default, no parity, one-bit sync tolerance)
// share one serial line; a bit-level frame decoder predicts every delivered word.
module tb_param_frame_receiver;

    localparam logic [7:0] SYNC = 8'hD8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic data_i;
    logic rand_rdy;
    logic rdy_fix;
    logic rnd_bit;
    logic rdy;
    assign rdy = rand_rdy ? rnd_bit : rdy_fix;

    logic [7:0]  o_data [3];
    logic        o_perr [3];
    logic        o_valid[3];
    logic        o_lock [3];
    logic        o_ovf  [3];
    logic [15:0] o_cnt  [3];

    param_frame_receiver u_dut (
        .clk(clk), .reset(reset), .data_i(data_i),
        .out_data(o_data[0]), .out_perr(o_perr[0]), .out_valid(o_valid[0]),
        .out_ready(rdy), .sync_lock(o_lock[0]), .overflow(o_ovf[0]), .frame_cnt(o_cnt[0])
    );

    param_frame_receiver #(.PARITY_EN(1'b0)) u_np (
        .clk(clk), .reset(reset), .data_i(data_i),
        .out_data(o_data[1]), .out_perr(o_perr[1]), .out_valid(o_valid[1]),
        .out_ready(1'b1), .sync_lock(o_lock[1]), .overflow(o_ovf[1]), .frame_cnt(o_cnt[1])
    );

    param_frame_receiver #(.MAX_ERR(1)) u_e1 (
        .clk(clk), .reset(reset), .data_i(data_i),
        .out_data(o_data[2]), .out_perr(o_perr[2]), .out_valid(o_valid[2]),
        .out_ready(1'b1), .sync_lock(o_lock[2]), .overflow(o_ovf[2]), .frame_cnt(o_cnt[2])
    );

    typedef struct {
        logic [7:0]  data;
        logic        perr;
        logic [15:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference decoder state per build
    logic [7:0] m_win [3];
    int         m_need[3];
    logic [8:0] m_bits[3];
    int         m_cnt [3];

    function automatic int cfg_par(input int c);
        return (c == 1) ? 0 : 1;
    endfunction

    function automatic int cfg_err(input int c);
        return (c == 2) ? 1 : 0;
    endfunction

    function automatic int q_size(input int c);
        case (c)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int c, input exp_t e);
        case (c)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            m_win[c]  = '0;
            m_need[c] = 0;
            m_bits[c] = '0;
            m_cnt[c]  = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Hunt: last 8 bits within the allowed Hamming distance of SYNC starts a frame.
    // Frame: the next 8 (+1 parity) bits; perr is set when the ones among them are odd.
    task automatic model_bit(input logic b);
        for (int c = 0; c < 3; c++) begin
            if (m_need[c] == 0) begin
                m_win[c] = {m_win[c][6:0], b};
                if ($countones(m_win[c] ^ SYNC) <= cfg_err(c)) begin
                    m_need[c] = 8 + cfg_par(c);
                    m_bits[c] = '0;
                end
            end else begin
                m_bits[c] = {m_bits[c][7:0], b};
                m_need[c]--;
                if (m_need[c] == 0) begin
                    exp_t e;
                    if (cfg_par(c) != 0) begin
                        e.data = m_bits[c][8:1];
                        e.perr = ^m_bits[c];
                    end else begin
                        e.data = m_bits[c][7:0];
                        e.perr = 1'b0;
                    end
                    m_cnt[c]++;
                    e.cnt = 16'(m_cnt[c]);
                    push_exp(c, e);
                    m_win[c] = '0;
                end
            end
        end
    endtask

    task automatic check_out(input int c);
        exp_t e;
        n_cmp++;
        if (q_size(c) == 0) begin
            n_bad++;
            $display("FAIL unexpected_word[%0d]: got data %0h cnt %0d, expected no word", c, o_data[c], o_cnt[c]);
            return;
        end
        n_cmp--;
        case (c)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("data[%0d]", c),  32'(o_data[c]),  32'(e.data));
        chk($sformatf("perr[%0d]", c),  32'(o_perr[c]),  32'(e.perr));
        chk($sformatf("cnt[%0d]", c),   32'(o_cnt[c]),   32'(e.cnt));
        chk($sformatf("valid[%0d]", c), 32'(o_valid[c]), 32'd1);
    endtask

    // monitor: every frame_cnt step outside reset is one delivered word
    logic [15:0] prev_cnt[3];
    initial begin
        for (int c = 0; c < 3; c++) prev_cnt[c] = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if (reset === 1'b1 && o_cnt[c] != prev_cnt[c]) check_out(c);
                prev_cnt[c] = o_cnt[c];
            end
        end
    end

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(negedge clk);
            rnd_bit = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input int per, input int glitch);
        for (int i = 0; i < per; i++) begin
            @(negedge clk);
            data_i = (i == glitch) ? ~b : b;
        end
        model_bit(b);
    endtask

    task automatic send_byte(input logic [7:0] v, input int per, input int gbit);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i], per, ((7 - i) == gbit) ? 6 : -1);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 8, -1);
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] p, input logic pb,
                              input bit has_par, input int per, input int gbit);
        send_byte(s, per, -1);
        send_byte(p, per, gbit);
        if (has_par) send_bit(pb, per, -1);
        send_idle(12);
    endtask

    logic [7:0] rs, rp;
    logic       rpb;

    initial begin
        reset    = 1'b0;
        data_i   = 1'b0;
        rand_rdy = 1'b0;
        rdy_fix  = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(o_data[0]),  32'd0);
        chk("rst_perr",  32'(o_perr[0]),  32'd0);
        chk("rst_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_lock",  32'(o_lock[0]),  32'd0);
        chk("rst_ovf",   32'(o_ovf[0]),   32'd0);
        chk("rst_cnt",   32'(o_cnt[0]),   32'd0);
        reset = 1'b1;

        // basic frame, then parity error, then a frame sent without a parity bit
        send_idle(16);
        send_frame(SYNC, 8'h3C, 1'b0, 1'b1, 8, -1);
        chk("t1_cnt", 32'(o_cnt[0]), 32'd1);
        send_idle(16);
        send_frame(SYNC, 8'h3C, 1'b1, 1'b1, 8, -1);
        send_idle(16);
        send_frame(SYNC, 8'h3C, 1'b0, 1'b0, 8, -1);

        // random frames, some with a corrupted sync bit or a wrong parity bit
        rand_rdy = 1'b1;
        for (int f = 0; f < 12; f++) begin
            send_idle(int'($urandom_range(2, 6)));
            rs = SYNC;
            if ($urandom_range(0, 3) == 0) rs = rs ^ (8'h01 << $urandom_range(0, 7));
            rp  = 8'($urandom);
            rpb = (^rp) ^ ($urandom_range(0, 3) == 0);
            send_byte(rs, 8, -1);
            send_byte(rp, 8, -1);
            send_bit(rpb, 8, -1);
        end
        send_idle(16);
        rand_rdy = 1'b0;
        rdy_fix  = 1'b1;
        chk("rand_ovf", 32'(o_ovf[0]), 32'd0);
        for (int c = 0; c < 3; c++)
            chk($sformatf("rand_cnt[%0d]", c), 32'(o_cnt[c]), 32'(m_cnt[c]));

        // sync with one bit error: only the tolerant build locks
        send_idle(16);
        send_byte(8'hD9, 8, -1);
        send_bit(1'b0, 8, -1);
        chk("t4_lock_strict", 32'(o_lock[0]), 32'd0);
        chk("t4_lock_tol",    32'(o_lock[2]), 32'd1);
        for (int i = 6; i >= 0; i--) send_bit(rp[i] & 1'b0 | ((8'h24 >> i) & 8'h01) != 0, 8, -1);
        send_bit(1'b0, 8, -1);
        send_idle(12);

        // 9-clock bit period against OSR=8, then a one-clock glitch on a sampled bit
        send_idle(16);
        send_frame(SYNC, 8'h55, 1'b0, 1'b1, 9, -1);
        send_idle(16);
        send_frame(SYNC, 8'h55, 1'b0, 1'b1, 8, 3);
        chk("t5_data", 32'(o_data[0]), 32'h55);

        // stalled consumer: second word overwrites the first
        rdy_fix = 1'b0;
        send_idle(16);
        send_frame(SYNC, 8'hA5, 1'b0, 1'b1, 8, -1);
        chk("t3_ovf_first",   32'(o_ovf[0]),   32'd0);
        chk("t3_valid_first", 32'(o_valid[0]), 32'd1);
        send_frame(SYNC, 8'h5A, 1'b0, 1'b1, 8, -1);
        chk("t3_data",  32'(o_data[0]),  32'h5A);
        chk("t3_ovf",   32'(o_ovf[0]),   32'd1);
        chk("t3_valid", 32'(o_valid[0]), 32'd1);
        rdy_fix = 1'b1;
        @(negedge clk);
        chk("t3_valid_clr", 32'(o_valid[0]), 32'd0);

        // reset in the middle of a payload
        send_idle(16);
        send_byte(SYNC, 8, -1);
        send_bit(1'b1, 8, -1);
        send_bit(1'b0, 8, -1);
        send_bit(1'b1, 8, -1);
        send_bit(1'b1, 8, -1);
        chk("t6_lock_pre", 32'(o_lock[0]), 32'd1);
        @(negedge clk);
        data_i = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_data",  32'(o_data[0]),  32'd0);
        chk("t6_valid", 32'(o_valid[0]), 32'd0);
        chk("t6_lock",  32'(o_lock[0]),  32'd0);
        chk("t6_ovf",   32'(o_ovf[0]),   32'd0);
        chk("t6_cnt",   32'(o_cnt[0]),   32'd0);
        model_clear();
        @(negedge clk);
        data_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        send_idle(16);
        send_frame(SYNC, 8'h81, 1'b0, 1'b1, 8, -1);
        chk("t6_cnt_after",  32'(o_cnt[0]),  32'd1);
        chk("t6_data_after", 32'(o_data[0]), 32'h81);

        for (int i = 0; i < 300 && (q0.size() + q1.size() + q2.size()) != 0; i++)
            @(negedge clk);
        for (int c = 0; c < 3; c++)
            chk($sformatf("pending[%0d]", c), 32'(q_size(c)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
